// File: rtl/bit_packer.sv
// Variable-length code packer: concatenates right-aligned codes MSB-first
// into a double-width accumulator and streams out packed words.
module bit_packer #(
  parameter int OUT_WIDTH  = 32,
  parameter int CODE_WIDTH = 32,
  parameter int LEN_WIDTH  = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CODE_WIDTH-1:0]      code_in,
  input  logic [LEN_WIDTH-1:0]       code_len,
  input  logic                       in_valid,
  input  logic                       flush,
  output logic                       in_ready,
  output logic [OUT_WIDTH-1:0]       out_data,
  output logic [$clog2(OUT_WIDTH):0] out_bits,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       flush_done
);

  localparam int ACC_W = 2 * OUT_WIDTH;
  localparam int FW    = $clog2(ACC_W) + 1;
  localparam int BW    = $clog2(OUT_WIDTH) + 1;

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [FW-1:0]        ACC_W_F = FW'(ACC_W);
  localparam logic [FW-1:0]        OUT_W_F = FW'(OUT_WIDTH);
  localparam logic [FW-1:0]        CODE_F  = FW'(CODE_WIDTH);
  localparam logic [LEN_WIDTH-1:0] CODE_L  = LEN_WIDTH'(CODE_WIDTH);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FW-1:0]    fill_q, fill_d;
  logic [0:0]       state_q, state_d;
  logic             done_q, done_d;

  logic [FW-1:0]    eff_len;
  logic [ACC_W-1:0] code_mask;
  logic [ACC_W-1:0] code_ext;
  logic [FW-1:0]    shamt;
  logic [ACC_W-1:0] packed_code;
  logic [ACC_W-1:0] acc_n;
  logic [FW-1:0]    fill_n;

  logic full;
  logic in_flush;
  logic accept;
  logic emit;

  assign full     = fill_q >= OUT_W_F;
  assign in_flush = state_q == S_FLUSH;

  // A flush drains everything left, including a sub-word tail.
  assign out_valid = full || (in_flush && (fill_q != '0));
  assign out_last  = out_valid && in_flush && (fill_q <= OUT_W_F);
  assign out_data  = acc_q[ACC_W-1 -: OUT_WIDTH];
  assign out_bits  = !out_valid ? '0 :
                     (in_flush && !full) ? BW'(fill_q) :
                     BW'(OUT_WIDTH);

  assign in_ready   = !rst && (state_q == S_RUN) && !full;
  assign flush_done = done_q;

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  // Oversized lengths saturate to the full code width.
  assign eff_len = (code_len > CODE_L) ? CODE_F : FW'(code_len);

  assign code_mask = ~({ACC_W{1'b1}} << eff_len);
  assign code_ext  = {{(ACC_W-CODE_WIDTH){1'b0}}, code_in} & code_mask;
  assign shamt     = ACC_W_F - fill_q - eff_len;

  assign packed_code = code_ext << shamt;

  assign acc_n  = accept ? (acc_q | packed_code) : acc_q;
  assign fill_n = accept ? (fill_q + eff_len) : fill_q;

  always_comb begin
    acc_d   = acc_q;
    fill_d  = fill_q;
    state_d = state_q;
    done_d  = 1'b0;
    unique case (1'b1)
      emit && out_last: begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = S_RUN;
        done_d  = 1'b1;
      end
      emit && !out_last: begin
        acc_d  = acc_q << OUT_WIDTH;
        fill_d = fill_q - OUT_W_F;
      end
      in_ready: begin
        acc_d  = acc_n;
        fill_d = fill_n;
        if (flush) begin
          if (fill_n == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      fill_q  <= '0;
      state_q <= S_RUN;
      done_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_bit_packer.sv
// Directed bench for bit_packer: packing, masking, back-pressure,
// flush tails and mid-stream reset.
module tb_bit_packer;

  logic        clk;
  logic        rst;
  logic [31:0] code_in;
  logic [5:0]  code_len;
  logic        in_valid;
  logic        flush;
  logic        in_ready;
  logic [31:0] out_data;
  logic [5:0]  out_bits;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;
  logic        flush_done;

  int n_chk;
  int n_err;

  bit_packer dut (
    .clk       (clk),
    .rst       (rst),
    .code_in   (code_in),
    .code_len  (code_len),
    .in_valid  (in_valid),
    .flush     (flush),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_bits  (out_bits),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush_done(flush_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] c, input logic [5:0] l,
                      input logic v, input logic f);
    code_in  = c;
    code_len = l;
    in_valid = v;
    flush    = f;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    code_in  = '0;
    code_len = '0;
  endtask

  logic [31:0] held;

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    code_in = '0;
    code_len = '0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    n_chk = 0;
    n_err = 0;

    tick();
    tick();
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();
    chk("rst_in_ready_post", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bits", out_bits, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_flush_done", flush_done, 0);

    // 1: four bytes
    send(32'hAA, 6'd8, 1, 0);
    send(32'hBB, 6'd8, 1, 0);
    send(32'hCC, 6'd8, 1, 0);
    chk("t1_valid_early", out_valid, 0);
    send(32'hDD, 6'd8, 1, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 32'hAABBCCDD);
    chk("t1_bits", out_bits, 32);
    chk("t1_last", out_last, 0);
    chk("t1_in_ready_low", in_ready, 0);
    tick();
    chk("t1_valid_drop", out_valid, 0);
    chk("t1_in_ready_back", in_ready, 1);

    // 2: 20-bit codes then bare flush
    send(32'hABCDE, 6'd20, 1, 0);
    send(32'h12345, 6'd20, 1, 0);
    chk("t2_data", out_data, 32'hABCDE123);
    chk("t2_valid", out_valid, 1);
    tick();
    chk("t2_valid_drop", out_valid, 0);
    send(32'h0, 6'd0, 0, 1);
    chk("t2_tail_valid", out_valid, 1);
    chk("t2_tail_data", out_data, 32'h45000000);
    chk("t2_tail_bits", out_bits, 8);
    chk("t2_tail_last", out_last, 1);
    chk("t2_flush_in_ready", in_ready, 0);
    tick();
    chk("t2_done", flush_done, 1);
    chk("t2_valid_after", out_valid, 0);
    chk("t2_in_ready_after", in_ready, 1);
    tick();
    chk("t2_done_pulse", flush_done, 0);

    // 3: masking and length saturation
    send(32'hFFFFFFFF, 6'd4, 1, 0);
    send(32'h0, 6'd28, 1, 0);
    chk("t3_mask_data", out_data, 32'hF0000000);
    chk("t3_mask_valid", out_valid, 1);
    tick();
    send(32'h12345678, 6'd40, 1, 0);
    chk("t3_sat_valid", out_valid, 1);
    chk("t3_sat_data", out_data, 32'h12345678);
    chk("t3_sat_bits", out_bits, 32);
    tick();
    chk("t3_sat_drained", out_valid, 0);

    // 4: back-pressure
    out_ready = 1'b0;
    send(32'h01, 6'd8, 1, 0);
    send(32'h02, 6'd8, 1, 0);
    send(32'h03, 6'd8, 1, 0);
    send(32'h04, 6'd8, 1, 0);
    held = 32'h01020304;
    for (int i = 0; i < 5; i++) begin
      chk("t4_hold_valid", out_valid, 1);
      chk("t4_hold_data", out_data, held);
      chk("t4_hold_bits", out_bits, 32);
      chk("t4_hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("t4_release", out_valid, 0);
    chk("t4_in_ready", in_ready, 1);

    // 5: flush together with a code, then an empty flush
    send(32'hAABBCC, 6'd24, 1, 0);
    chk("t5_no_word", out_valid, 0);
    send(32'hDDEE, 6'd16, 1, 1);
    chk("t5_w0_valid", out_valid, 1);
    chk("t5_w0_data", out_data, 32'hAABBCCDD);
    chk("t5_w0_last", out_last, 0);
    chk("t5_w0_bits", out_bits, 32);
    chk("t5_w0_done", flush_done, 0);
    tick();
    chk("t5_w1_valid", out_valid, 1);
    chk("t5_w1_data", out_data, 32'hEE000000);
    chk("t5_w1_bits", out_bits, 8);
    chk("t5_w1_last", out_last, 1);
    tick();
    chk("t5_done", flush_done, 1);
    chk("t5_valid_after", out_valid, 0);
    tick();
    chk("t5_done_pulse", flush_done, 0);
    send(32'h0, 6'd0, 0, 1);
    chk("t5_empty_done", flush_done, 1);
    chk("t5_empty_valid", out_valid, 0);
    chk("t5_empty_in_ready", in_ready, 1);
    tick();
    chk("t5_empty_pulse", flush_done, 0);

    // 6: reset mid-stream
    send(32'hABCDE, 6'd20, 1, 0);
    chk("t6_pre_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    chk("t6_rst_in_ready", in_ready, 0);
    chk("t6_rst_valid", out_valid, 0);
    rst = 1'b0;
    chk("t6_rst_data", out_data, 0);
    send(32'h11, 6'd8, 1, 0);
    send(32'h11, 6'd8, 1, 0);
    send(32'h11, 6'd8, 1, 0);
    send(32'h11, 6'd8, 1, 0);
    chk("t6_valid", out_valid, 1);
    chk("t6_data", out_data, 32'h11111111);
    tick();
    chk("t6_clean_valid", out_valid, 0);
    chk("t6_clean_data", out_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
